// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS-lite datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Every cycle it drives
// the datapath enables and mux selects, waits on the memory ready handshakes, and
// counts retired instructions.
module multicycle_ctrl #(
   parameter int USE_READY = 1,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             PCWr,
   output logic             IRWr,
   output logic [1:0]       PCsel,
   output logic             RFWr,
   output logic [1:0]       WRsel,
   output logic [1:0]       WDsel,
   output logic             EXTOp,
   output logic             Bsel,
   output logic [1:0]       ALUOp,
   output logic             Sll,
   output logic             LUIsel,
   output logic             DMWr,
   output logic             MDRWr,
   output logic             instr_done,
   output logic             illegal,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state
);

   // Opcode and funct encodings
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_JR    = 6'b001000;

   // Mux select encodings
   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_BR    = 2'b01;
   localparam logic [1:0] PC_JAL   = 2'b10;
   localparam logic [1:0] PC_REG   = 2'b11;
   localparam logic [1:0] WR_RT    = 2'b00;
   localparam logic [1:0] WR_RD    = 2'b01;
   localparam logic [1:0] WR_RA    = 2'b10;
   localparam logic [1:0] WD_ALU   = 2'b00;
   localparam logic [1:0] WD_MDR   = 2'b01;
   localparam logic [1:0] WD_PC    = 2'b10;
   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_OR   = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      I_ADDU, I_SUBU, I_SLL, I_JR, I_ORI, I_LW,
      I_SW, I_BEQ, I_LUI, I_JAL, I_BAD
   } instr_t;

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] instret_reg;
   instr_t           instr;
   logic             rdy_i;
   logic             rdy_d;
   logic             retire;

   // Per-instruction ALU controls, shared by EXEC and the ALU-result WB cycle
   logic [1:0]       alu_op_dec;
   logic             bsel_dec;
   logic             extop_dec;
   logic             sll_dec;
   logic             lui_dec;

   // With the handshake disabled, memories are treated as always ready
   assign rdy_i = (USE_READY != 0) ? imem_ready : 1'b1;
   assign rdy_d = (USE_READY != 0) ? dmem_ready : 1'b1;

   // Classify the instruction held in IR
   always_comb begin
      instr = I_BAD;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: instr = I_ADDU;
               FN_SUBU: instr = I_SUBU;
               FN_SLL:  instr = I_SLL;
               FN_JR:   instr = I_JR;
               default: instr = I_BAD;
            endcase
         end
         OP_ORI:  instr = I_ORI;
         OP_LW:   instr = I_LW;
         OP_SW:   instr = I_SW;
         OP_BEQ:  instr = I_BEQ;
         OP_LUI:  instr = I_LUI;
         OP_JAL:  instr = I_JAL;
         default: instr = I_BAD;
      endcase
   end

   // ALU control decode: operation, B source, immediate extension, special paths
   always_comb begin
      alu_op_dec = ALU_ADD;
      bsel_dec   = 1'b0;
      extop_dec  = 1'b0;
      sll_dec    = 1'b0;
      lui_dec    = 1'b0;
      case (instr)
         I_SUBU, I_BEQ: alu_op_dec = ALU_SUB;
         I_ORI: begin
            alu_op_dec = ALU_OR;
            bsel_dec   = 1'b1;
         end
         I_LW, I_SW: begin
            bsel_dec  = 1'b1;
            extop_dec = 1'b1;
         end
         I_LUI: begin
            bsel_dec = 1'b1;
            lui_dec  = 1'b1;
         end
         I_SLL:   sll_dec = 1'b1;
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      if (reset) begin
         instret_reg <= '0;
      end else if (retire) begin
         instret_reg <= instret_reg + CNT_W'(1);
      end
   end

   // Next-state and datapath control outputs; reset forces every control low
   always_comb begin
      state_next = state_reg;
      retire     = 1'b0;
      PCWr       = 1'b0;
      IRWr       = 1'b0;
      PCsel      = PC_PLUS4;
      RFWr       = 1'b0;
      WRsel      = WR_RT;
      WDsel      = WD_ALU;
      EXTOp      = 1'b0;
      Bsel       = 1'b0;
      ALUOp      = ALU_ADD;
      Sll        = 1'b0;
      LUIsel     = 1'b0;
      DMWr       = 1'b0;
      MDRWr      = 1'b0;
      illegal    = 1'b0;

      case (state_reg)
         S_FETCH: begin
            IRWr = rdy_i;
            PCWr = rdy_i;
            if (rdy_i) begin
               state_next = S_DECODE;
            end
         end

         S_DECODE: begin
            case (instr)
               I_JAL: begin
                  RFWr   = 1'b1;
                  WRsel  = WR_RA;
                  WDsel  = WD_PC;
                  PCWr   = 1'b1;
                  PCsel  = PC_JAL;
                  retire = 1'b1;
               end
               I_JR: begin
                  PCWr   = 1'b1;
                  PCsel  = PC_REG;
                  retire = 1'b1;
               end
               I_BAD: begin
                  // Unsupported encodings complete as a NOP so the program keeps going
                  illegal = 1'b1;
                  retire  = 1'b1;
               end
               default: state_next = S_EXEC;
            endcase
         end

         S_EXEC: begin
            ALUOp  = alu_op_dec;
            Bsel   = bsel_dec;
            EXTOp  = extop_dec;
            Sll    = sll_dec;
            LUIsel = lui_dec;
            case (instr)
               I_BEQ: begin
                  PCWr   = zero;
                  PCsel  = PC_BR;
                  retire = 1'b1;
               end
               I_LW, I_SW:                          state_next = S_MEM;
               I_ADDU, I_SUBU, I_SLL, I_ORI, I_LUI: state_next = S_WB;
               default:                             state_next = S_FETCH;
            endcase
         end

         S_MEM: begin
            // Keep the address computation live while the memory may stall
            Bsel  = 1'b1;
            EXTOp = 1'b1;
            ALUOp = ALU_ADD;
            case (instr)
               I_SW: begin
                  DMWr = 1'b1;
                  if (rdy_d) begin
                     retire = 1'b1;
                  end
               end
               I_LW: begin
                  MDRWr = rdy_d;
                  if (rdy_d) begin
                     state_next = S_WB;
                  end
               end
               default: state_next = S_FETCH;
            endcase
         end

         S_WB: begin
            RFWr   = 1'b1;
            retire = 1'b1;
            case (instr)
               I_LW: begin
                  WRsel = WR_RT;
                  WDsel = WD_MDR;
               end
               I_ADDU, I_SUBU, I_SLL: begin
                  WRsel  = WR_RD;
                  WDsel  = WD_ALU;
                  ALUOp  = alu_op_dec;
                  Bsel   = bsel_dec;
                  EXTOp  = extop_dec;
                  Sll    = sll_dec;
                  LUIsel = lui_dec;
               end
               default: begin
                  WRsel  = WR_RT;
                  WDsel  = WD_ALU;
                  ALUOp  = alu_op_dec;
                  Bsel   = bsel_dec;
                  EXTOp  = extop_dec;
                  Sll    = sll_dec;
                  LUIsel = lui_dec;
               end
            endcase
         end

         default: state_next = S_FETCH;
      endcase

      if (retire) begin
         state_next = S_FETCH;
      end

      // Reset drops any pending write and suppresses retirement in the same cycle
      if (reset) begin
         retire  = 1'b0;
         PCWr    = 1'b0;
         IRWr    = 1'b0;
         PCsel   = PC_PLUS4;
         RFWr    = 1'b0;
         WRsel   = WR_RT;
         WDsel   = WD_ALU;
         EXTOp   = 1'b0;
         Bsel    = 1'b0;
         ALUOp   = ALU_ADD;
         Sll     = 1'b0;
         LUIsel  = 1'b0;
         DMWr    = 1'b0;
         MDRWr   = 1'b0;
         illegal = 1'b0;
      end
   end

   assign instr_done = retire;
   assign state      = reset ? 3'd0 : state_reg;
   assign instret    = reset ? '0 : instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors,
// plus a narrow-counter instance to exercise instret wrap-around.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  op = '0;
   logic [5:0]  funct = '0;
   logic        zero = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;

   logic        PCWr, IRWr, RFWr, EXTOp, Bsel, Sll, LUIsel, DMWr, MDRWr;
   logic        instr_done, illegal;
   logic [1:0]  PCsel, WRsel, WDsel, ALUOp;
   logic [31:0] instret;
   logic [2:0]  state;

   logic        d2_PCWr, d2_IRWr, d2_RFWr, d2_EXTOp, d2_Bsel, d2_Sll, d2_LUIsel;
   logic        d2_DMWr, d2_MDRWr, d2_instr_done, d2_illegal;
   logic [1:0]  d2_PCsel, d2_WRsel, d2_WDsel, d2_ALUOp;
   logic [1:0]  d2_instret;
   logic [2:0]  d2_state;

   int          total = 0;
   int          bad = 0;
   int          exp_cnt = 0;

   // Observed control vector, MSB first: state, PCWr, IRWr, PCsel, RFWr, WRsel,
   // WDsel, EXTOp, Bsel, ALUOp, Sll, LUIsel, DMWr, MDRWr, instr_done, illegal
   logic [21:0] obs;
   assign obs = {state, PCWr, IRWr, PCsel, RFWr, WRsel, WDsel, EXTOp, Bsel,
                 ALUOp, Sll, LUIsel, DMWr, MDRWr, instr_done, illegal};

   localparam logic [21:0] ILL     = 22'd1 << 0;
   localparam logic [21:0] DONE    = 22'd1 << 1;
   localparam logic [21:0] MDRWR   = 22'd1 << 2;
   localparam logic [21:0] DMWR    = 22'd1 << 3;
   localparam logic [21:0] LUI     = 22'd1 << 4;
   localparam logic [21:0] SLL     = 22'd1 << 5;
   localparam logic [21:0] ALU_SUB = 22'd1 << 6;
   localparam logic [21:0] ALU_OR  = 22'd2 << 6;
   localparam logic [21:0] BSEL    = 22'd1 << 8;
   localparam logic [21:0] EXT     = 22'd1 << 9;
   localparam logic [21:0] WD_MDR  = 22'd1 << 10;
   localparam logic [21:0] WD_PC   = 22'd2 << 10;
   localparam logic [21:0] WR_RD   = 22'd1 << 12;
   localparam logic [21:0] WR_31   = 22'd2 << 12;
   localparam logic [21:0] RFWR    = 22'd1 << 14;
   localparam logic [21:0] PC_BR   = 22'd1 << 15;
   localparam logic [21:0] PC_JAL  = 22'd2 << 15;
   localparam logic [21:0] PC_JR   = 22'd3 << 15;
   localparam logic [21:0] IRWR    = 22'd1 << 17;
   localparam logic [21:0] PCWR    = 22'd1 << 18;
   localparam logic [21:0] S_DEC   = 22'd1 << 19;
   localparam logic [21:0] S_EXE   = 22'd2 << 19;
   localparam logic [21:0] S_MEM   = 22'd3 << 19;
   localparam logic [21:0] S_WB    = 22'd4 << 19;
   localparam logic [21:0] FETCH_OK = PCWR | IRWR;

   // Per-cycle stimulus/expectation table: reset, op, funct, {imem,dmem,zero}, outputs
   logic        t_r  [32];
   logic [5:0]  t_op [32];
   logic [5:0]  t_fn [32];
   logic [2:0]  t_iv [32];
   logic [21:0] t_e  [32];
   int          n;

   multicycle_ctrl #(.USE_READY(1), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .PCWr(PCWr), .IRWr(IRWr), .PCsel(PCsel), .RFWr(RFWr), .WRsel(WRsel),
      .WDsel(WDsel), .EXTOp(EXTOp), .Bsel(Bsel), .ALUOp(ALUOp), .Sll(Sll),
      .LUIsel(LUIsel), .DMWr(DMWr), .MDRWr(MDRWr), .instr_done(instr_done),
      .illegal(illegal), .instret(instret), .state(state)
   );

   multicycle_ctrl #(.USE_READY(1), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .PCWr(d2_PCWr), .IRWr(d2_IRWr), .PCsel(d2_PCsel), .RFWr(d2_RFWr),
      .WRsel(d2_WRsel), .WDsel(d2_WDsel), .EXTOp(d2_EXTOp), .Bsel(d2_Bsel),
      .ALUOp(d2_ALUOp), .Sll(d2_Sll), .LUIsel(d2_LUIsel), .DMWr(d2_DMWr),
      .MDRWr(d2_MDRWr), .instr_done(d2_instr_done), .illegal(d2_illegal),
      .instret(d2_instret), .state(d2_state)
   );

   always #5 clk = ~clk;

   task automatic put(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic [2:0] iv, input logic [21:0] e);
      t_r[n] = r; t_op[n] = o; t_fn[n] = f; t_iv[n] = iv; t_e[n] = e;
      n++;
   endtask

   task automatic test_reset();
      n = 0;
      put(1'b1, 6'h00, 6'h21, 3'b110, '0);
      put(1'b1, 6'h23, 6'h00, 3'b111, '0);
      put(0, 6'h00, 6'h21, 3'b000, '0);   // FETCH stalled: no IR/PC write
      for (int i = 0; i < n; i++) begin
         reset = t_r[i]; op = t_op[i]; funct = t_fn[i];
         {imem_ready, dmem_ready, zero} = t_iv[i];
         #1;
         total++;
         if (obs !== t_e[i]) begin
            bad++;
            $display("FAIL reset cyc%0d outputs=%h required=%h", i, obs, t_e[i]);
         end
         if (t_r[i]) exp_cnt = 0; else if (t_e[i][1]) exp_cnt++;
         @(posedge clk); #1;
      end
      total++;
      if (instret !== 32'(exp_cnt)) begin
         bad++;
         $display("FAIL reset_instret instret=%0d required=%0d", instret, exp_cnt);
      end
   endtask

   task automatic test_addu();
      n = 0;
      put(0, 6'h00, 6'h21, 3'b110, FETCH_OK);
      put(0, 6'h00, 6'h21, 3'b110, S_DEC);
      put(0, 6'h00, 6'h21, 3'b110, S_EXE);
      put(0, 6'h00, 6'h21, 3'b110, S_WB | RFWR | WR_RD | DONE);
      for (int i = 0; i < n; i++) begin
         reset = t_r[i]; op = t_op[i]; funct = t_fn[i];
         {imem_ready, dmem_ready, zero} = t_iv[i];
         #1;
         total++;
         if (obs !== t_e[i]) begin
            bad++;
            $display("FAIL addu cyc%0d outputs=%h required=%h", i, obs, t_e[i]);
         end
         if (t_r[i]) exp_cnt = 0; else if (t_e[i][1]) exp_cnt++;
         @(posedge clk); #1;
      end
      total++;
      if (instret !== 32'(exp_cnt)) begin
         bad++;
         $display("FAIL addu_instret instret=%0d required=%0d", instret, exp_cnt);
      end
   endtask

   task automatic test_lw_stall();
      n = 0;
      put(0, 6'h23, 6'h00, 3'b110, FETCH_OK);
      put(0, 6'h23, 6'h00, 3'b110, S_DEC);
      put(0, 6'h23, 6'h00, 3'b100, S_EXE | BSEL | EXT);
      put(0, 6'h23, 6'h00, 3'b100, S_MEM | BSEL | EXT);
      put(0, 6'h23, 6'h00, 3'b100, S_MEM | BSEL | EXT);
      put(0, 6'h23, 6'h00, 3'b100, S_MEM | BSEL | EXT);
      put(0, 6'h23, 6'h00, 3'b110, S_MEM | BSEL | EXT | MDRWR);
      put(0, 6'h23, 6'h00, 3'b110, S_WB | RFWR | WD_MDR | DONE);
      for (int i = 0; i < n; i++) begin
         reset = t_r[i]; op = t_op[i]; funct = t_fn[i];
         {imem_ready, dmem_ready, zero} = t_iv[i];
         #1;
         total++;
         if (obs !== t_e[i]) begin
            bad++;
            $display("FAIL lw_stall cyc%0d outputs=%h required=%h", i, obs, t_e[i]);
         end
         if (t_r[i]) exp_cnt = 0; else if (t_e[i][1]) exp_cnt++;
         @(posedge clk); #1;
      end
      total++;
      if (instret !== 32'(exp_cnt)) begin
         bad++;
         $display("FAIL lw_instret instret=%0d required=%0d", instret, exp_cnt);
      end
   endtask

   task automatic test_beq();
      n = 0;
      put(0, 6'h04, 6'h00, 3'b010, '0);   // imem stall holds FETCH
      put(0, 6'h04, 6'h00, 3'b110, FETCH_OK);
      put(0, 6'h04, 6'h00, 3'b110, S_DEC);
      put(0, 6'h04, 6'h00, 3'b111, S_EXE | ALU_SUB | PCWR | PC_BR | DONE);
      put(0, 6'h04, 6'h00, 3'b110, FETCH_OK);
      put(0, 6'h04, 6'h00, 3'b110, S_DEC);
      put(0, 6'h04, 6'h00, 3'b110, S_EXE | ALU_SUB | PC_BR | DONE);
      for (int i = 0; i < n; i++) begin
         reset = t_r[i]; op = t_op[i]; funct = t_fn[i];
         {imem_ready, dmem_ready, zero} = t_iv[i];
         #1;
         total++;
         if (obs !== t_e[i]) begin
            bad++;
            $display("FAIL beq cyc%0d outputs=%h required=%h", i, obs, t_e[i]);
         end
         if (t_r[i]) exp_cnt = 0; else if (t_e[i][1]) exp_cnt++;
         @(posedge clk); #1;
      end
      total++;
      if (instret !== 32'(exp_cnt)) begin
         bad++;
         $display("FAIL beq_instret instret=%0d required=%0d", instret, exp_cnt);
      end
   endtask

   task automatic test_jal_jr();
      n = 0;
      put(0, 6'h03, 6'h00, 3'b110, FETCH_OK);
      put(0, 6'h03, 6'h00, 3'b110, S_DEC | RFWR | WR_31 | WD_PC | PCWR | PC_JAL | DONE);
      put(0, 6'h00, 6'h08, 3'b110, FETCH_OK);
      put(0, 6'h00, 6'h08, 3'b110, S_DEC | PCWR | PC_JR | DONE);
      for (int i = 0; i < n; i++) begin
         reset = t_r[i]; op = t_op[i]; funct = t_fn[i];
         {imem_ready, dmem_ready, zero} = t_iv[i];
         #1;
         total++;
         if (obs !== t_e[i]) begin
            bad++;
            $display("FAIL jal_jr cyc%0d outputs=%h required=%h", i, obs, t_e[i]);
         end
         if (t_r[i]) exp_cnt = 0; else if (t_e[i][1]) exp_cnt++;
         @(posedge clk); #1;
      end
      total++;
      if (instret !== 32'(exp_cnt)) begin
         bad++;
         $display("FAIL jal_jr_instret instret=%0d required=%0d", instret, exp_cnt);
      end
   endtask

   task automatic test_illegal();
      n = 0;
      put(0, 6'h3f, 6'h00, 3'b110, FETCH_OK);
      put(0, 6'h3f, 6'h00, 3'b110, S_DEC | ILL | DONE);
      put(0, 6'h00, 6'h2a, 3'b010, '0);   // unknown funct, FETCH stalled
      for (int i = 0; i < n; i++) begin
         reset = t_r[i]; op = t_op[i]; funct = t_fn[i];
         {imem_ready, dmem_ready, zero} = t_iv[i];
         #1;
         total++;
         if (obs !== t_e[i]) begin
            bad++;
            $display("FAIL illegal cyc%0d outputs=%h required=%h", i, obs, t_e[i]);
         end
         if (t_r[i]) exp_cnt = 0; else if (t_e[i][1]) exp_cnt++;
         @(posedge clk); #1;
      end
      total++;
      if (instret !== 32'(exp_cnt)) begin
         bad++;
         $display("FAIL illegal_instret instret=%0d required=%0d", instret, exp_cnt);
      end
   endtask

   task automatic test_alu_types();
      n = 0;
      // ori
      put(0, 6'h0d, 6'h00, 3'b110, FETCH_OK);
      put(0, 6'h0d, 6'h00, 3'b110, S_DEC);
      put(0, 6'h0d, 6'h00, 3'b110, S_EXE | ALU_OR | BSEL);
      put(0, 6'h0d, 6'h00, 3'b110, S_WB | RFWR | ALU_OR | BSEL | DONE);
      // lui
      put(0, 6'h0f, 6'h00, 3'b110, FETCH_OK);
      put(0, 6'h0f, 6'h00, 3'b110, S_DEC);
      put(0, 6'h0f, 6'h00, 3'b110, S_EXE | BSEL | LUI);
      put(0, 6'h0f, 6'h00, 3'b110, S_WB | RFWR | BSEL | LUI | DONE);
      // sll
      put(0, 6'h00, 6'h00, 3'b110, FETCH_OK);
      put(0, 6'h00, 6'h00, 3'b110, S_DEC);
      put(0, 6'h00, 6'h00, 3'b110, S_EXE | SLL);
      put(0, 6'h00, 6'h00, 3'b110, S_WB | RFWR | WR_RD | SLL | DONE);
      // subu
      put(0, 6'h00, 6'h23, 3'b110, FETCH_OK);
      put(0, 6'h00, 6'h23, 3'b110, S_DEC);
      put(0, 6'h00, 6'h23, 3'b110, S_EXE | ALU_SUB);
      put(0, 6'h00, 6'h23, 3'b110, S_WB | RFWR | WR_RD | ALU_SUB | DONE);
      // sw, memory ready at once
      put(0, 6'h2b, 6'h00, 3'b110, FETCH_OK);
      put(0, 6'h2b, 6'h00, 3'b110, S_DEC);
      put(0, 6'h2b, 6'h00, 3'b110, S_EXE | BSEL | EXT);
      put(0, 6'h2b, 6'h00, 3'b110, S_MEM | BSEL | EXT | DMWR | DONE);
      for (int i = 0; i < n; i++) begin
         reset = t_r[i]; op = t_op[i]; funct = t_fn[i];
         {imem_ready, dmem_ready, zero} = t_iv[i];
         #1;
         total++;
         if (obs !== t_e[i]) begin
            bad++;
            $display("FAIL alu_types cyc%0d outputs=%h required=%h", i, obs, t_e[i]);
         end
         if (t_r[i]) exp_cnt = 0; else if (t_e[i][1]) exp_cnt++;
         @(posedge clk); #1;
      end
      total++;
      if (instret !== 32'(exp_cnt)) begin
         bad++;
         $display("FAIL alu_types_instret instret=%0d required=%0d", instret, exp_cnt);
      end
   endtask

   task automatic test_reset_mid();
      n = 0;
      put(1'b1, 6'h2b, 6'h00, 3'b110, '0);
      put(0, 6'h2b, 6'h00, 3'b110, FETCH_OK);
      put(0, 6'h2b, 6'h00, 3'b110, S_DEC);
      put(0, 6'h2b, 6'h00, 3'b100, S_EXE | BSEL | EXT);
      put(0, 6'h2b, 6'h00, 3'b100, S_MEM | BSEL | EXT | DMWR);
      put(1'b1, 6'h2b, 6'h00, 3'b110, '0);   // reset beats dmem_ready: no write, no retire
      put(0, 6'h2b, 6'h00, 3'b110, FETCH_OK);
      put(0, 6'h2b, 6'h00, 3'b010, S_DEC);
      put(0, 6'h2b, 6'h00, 3'b010, S_EXE | BSEL | EXT);
      put(0, 6'h2b, 6'h00, 3'b000, S_MEM | BSEL | EXT | DMWR);
      put(1'b1, 6'h2b, 6'h00, 3'b000, '0);
      put(0, 6'h2b, 6'h00, 3'b000, '0);      // back in FETCH, imem stalled
      for (int i = 0; i < n; i++) begin
         reset = t_r[i]; op = t_op[i]; funct = t_fn[i];
         {imem_ready, dmem_ready, zero} = t_iv[i];
         #1;
         total++;
         if (obs !== t_e[i]) begin
            bad++;
            $display("FAIL reset_mid cyc%0d outputs=%h required=%h", i, obs, t_e[i]);
         end
         if (t_r[i]) exp_cnt = 0; else if (t_e[i][1]) exp_cnt++;
         @(posedge clk); #1;
      end
      total++;
      if (instret !== 32'(exp_cnt)) begin
         bad++;
         $display("FAIL reset_mid_instret instret=%0d required=%0d", instret, exp_cnt);
      end
   endtask

   task automatic test_wrap();
      logic [1:0] exp2;
      reset = 1'b0; op = 6'h00; funct = 6'h08;
      {imem_ready, dmem_ready, zero} = 3'b110;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         @(posedge clk); #1;
         exp_cnt++;
         exp2 = 2'((k + 1) % 4);
         total++;
         if (d2_instret !== exp2) begin
            bad++;
            $display("FAIL wrap_cnt2 jr%0d instret=%0d required=%0d", k, d2_instret, exp2);
         end
         total++;
         if (instret !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL wrap_cnt32 jr%0d instret=%0d required=%0d", k, instret, exp_cnt);
         end
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_addu();
      test_lw_stall();
      test_beq();
      test_jal_jr();
      test_illegal();
      test_alu_types();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
